// File: rtl/timer_stats_if.sv
// Signal bundle between the cycle timer's strobes/count and the statistics block.
// master drives strobes, count and readout select; slave is the statistics block.
interface timer_stats_if #(
    parameter int SUM_W = 48,
    parameter int CNT_W = 16
);
    logic [31:0]      timer_in;
    logic             start;
    logic             stop;
    logic             clear;
    logic [2:0]       hist_sel;
    logic             meas_valid;
    logic [31:0]      last_meas;
    logic [31:0]      min_meas;
    logic [31:0]      max_meas;
    logic [SUM_W-1:0] sum_meas;
    logic [CNT_W-1:0] meas_count;
    logic             sum_ovf;
    logic             cnt_ovf;
    logic [15:0]      hist_cnt;

    modport master (
        output timer_in, start, stop, clear, hist_sel,
        input  meas_valid, last_meas, min_meas, max_meas, sum_meas,
               meas_count, sum_ovf, cnt_ovf, hist_cnt
    );

    modport slave (
        input  timer_in, start, stop, clear, hist_sel,
        output meas_valid, last_meas, min_meas, max_meas, sum_meas,
               meas_count, sum_ovf, cnt_ovf, hist_cnt
    );
endinterface

// File: rtl/timer_stats.sv
// Captures completed cycle-timer measurements and keeps last/min/max/sum/count stats.
// Optional 8-bin histogram enabled by defining TIMER_STATS_HIST_EN.
module timer_stats #(
    parameter int SUM_W     = 48,
    parameter int CNT_W     = 16,
    parameter int BIN_SHIFT = 4
) (
    input  logic         clk,
    input  logic         rst,
    timer_stats_if.slave bus
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic             stop_d_reg, stop_d_next;
    logic             valid_reg;
    logic [31:0]      last_reg, last_next;
    logic [31:0]      min_reg, min_next;
    logic [31:0]      max_reg, max_next;
    logic [SUM_W-1:0] sum_reg, sum_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             sum_ovf_reg, sum_ovf_next;
    logic             cnt_ovf_reg, cnt_ovf_next;
    logic [SUM_W:0]   sum_ext;
    logic [31:0]      m;

    assign m       = bus.timer_in;
    assign sum_ext = {1'b0, sum_reg} + (SUM_W+1)'(m);

    // Run tracking mirrors the upstream timer; start while idle wins over stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            stop_d_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            stop_d_reg <= stop_d_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        stop_d_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_next  = ST_IDLE;
                    stop_d_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        last_next    = last_reg;
        min_next     = min_reg;
        max_next     = max_reg;
        sum_next     = sum_reg;
        cnt_next     = cnt_reg;
        sum_ovf_next = sum_ovf_reg;
        cnt_ovf_next = cnt_ovf_reg;
        if (stop_d_reg) begin
            last_next = m;
            min_next  = (m < min_reg) ? m : min_reg;
            max_next  = (m > max_reg) ? m : max_reg;
            if (sum_ext[SUM_W]) begin
                sum_next     = '1;
                sum_ovf_next = 1'b1;
            end else begin
                sum_next = sum_ext[SUM_W-1:0];
            end
            if (&cnt_reg) begin
                cnt_ovf_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
        // Clear overrides a coincident capture.
        if (bus.clear) begin
            last_next    = '0;
            min_next     = '1;
            max_next     = '0;
            sum_next     = '0;
            cnt_next     = '0;
            sum_ovf_next = 1'b0;
            cnt_ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg   <= 1'b0;
            last_reg    <= '0;
            min_reg     <= '1;
            max_reg     <= '0;
            sum_reg     <= '0;
            cnt_reg     <= '0;
            sum_ovf_reg <= 1'b0;
            cnt_ovf_reg <= 1'b0;
        end else begin
            valid_reg   <= stop_d_reg;
            last_reg    <= last_next;
            min_reg     <= min_next;
            max_reg     <= max_next;
            sum_reg     <= sum_next;
            cnt_reg     <= cnt_next;
            sum_ovf_reg <= sum_ovf_next;
            cnt_ovf_reg <= cnt_ovf_next;
        end
    end

    assign bus.meas_valid = valid_reg;
    assign bus.last_meas  = last_reg;
    assign bus.min_meas   = min_reg;
    assign bus.max_meas   = max_reg;
    assign bus.sum_meas   = sum_reg;
    assign bus.meas_count = cnt_reg;
    assign bus.sum_ovf    = sum_ovf_reg;
    assign bus.cnt_ovf    = cnt_ovf_reg;

`ifdef TIMER_STATS_HIST_EN
    logic [31:0] shifted;
    logic [2:0]  bin_idx;
    logic [7:0]  bin_hit;
    logic [15:0] bin_reg [8];
    logic [15:0] hist_reg;

    assign shifted = m >> BIN_SHIFT;
    assign bin_idx = (shifted < 32'd8) ? shifted[2:0] : 3'd7;

    for (genvar gi = 0; gi < 8; gi++) begin : g_hit
        assign bin_hit[gi] = stop_d_reg && (bin_idx == 3'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_reg <= '0;
        end else begin
            hist_reg <= bin_reg[bus.hist_sel];
        end
        for (int i = 0; i < 8; i++) begin
            if (rst || bus.clear) begin
                bin_reg[i] <= '0;
            end else if (bin_hit[i] && !(&bin_reg[i])) begin
                bin_reg[i] <= bin_reg[i] + 16'd1;
            end
        end
    end

    assign bus.hist_cnt = hist_reg;
`else
    localparam int unused_bin_shift = BIN_SHIFT;
    logic unused_hist_sel;
    assign unused_hist_sel = ^bus.hist_sel;
    assign bus.hist_cnt    = '0;
`endif
endmodule

// File: tb/tb_timer_stats.sv
// Directed bench for timer_stats with a behavioural model of the upstream cycle timer.
module tb_timer_stats;
    localparam int SUM_W = 33;
    localparam int CNT_W = 4;
    localparam int BIN_SHIFT = 4;

    logic clk = 1'b0;
    logic rst;
    logic force_en;
    logic [31:0] force_val;
    logic [31:0] tval;
    logic trun;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_stats_if #(.SUM_W(SUM_W), .CNT_W(CNT_W)) bus ();

    timer_stats #(.SUM_W(SUM_W), .CNT_W(CNT_W), .BIN_SHIFT(BIN_SHIFT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Upstream timer: counts every cycle from the start edge through the stop edge.
    always @(posedge clk) begin
        if (rst) begin
            trun <= 1'b0;
            tval <= '0;
        end else if (trun && bus.stop && bus.start) begin
            trun <= 1'b0;
            tval <= '0;
        end else if (trun && bus.stop) begin
            trun <= 1'b0;
            tval <= tval + 1;
        end else if (bus.start) begin
            trun <= 1'b1;
            tval <= 32'd1;
        end else if (trun) begin
            tval <= tval + 1;
        end
    end

    assign bus.timer_in = force_en ? force_val : tval;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Measurement of m (m >= 2) cycles; returns one cycle after the capture edge.
    task automatic measure(input int m);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (m - 2) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        tick();
    endtask

    task automatic capture_forced(input logic [31:0] v);
        force_en  = 1'b1;
        force_val = v;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b1;
        tick();
        bus.stop  = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus.last_meas !== 32'd0 || bus.min_meas !== 32'hFFFFFFFF || bus.max_meas !== 32'd0 ||
            bus.sum_meas !== '0 || bus.meas_count !== '0 || bus.sum_ovf !== 1'b0 ||
            bus.cnt_ovf !== 1'b0 || bus.meas_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset: last=%0h min=%0h max=%0h sum=%0h cnt=%0d ovf=%b%b valid=%b, required 0/ffffffff/0/0/0/00/0",
                     bus.last_meas, bus.min_meas, bus.max_meas, bus.sum_meas, bus.meas_count,
                     bus.sum_ovf, bus.cnt_ovf, bus.meas_valid);
        end
        $display("reset: min=%0h", bus.min_meas);
    endtask

    task automatic test_single();
        repeat (8) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (99) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        checks++;
        if (bus.meas_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early_valid: meas_valid=%b required 0", bus.meas_valid);
        end
        tick();
        checks++;
        if (bus.meas_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_valid: meas_valid=%b required 1", bus.meas_valid);
        end
        checks++;
        if (bus.last_meas !== 32'd101 || bus.min_meas !== 32'd101 || bus.max_meas !== 32'd101 ||
            bus.sum_meas !== 33'd101 || bus.meas_count !== 4'd1) begin
            errors++;
            $display("FAIL single_stats: last=%0d min=%0d max=%0d sum=%0d cnt=%0d, required 101/101/101/101/1",
                     bus.last_meas, bus.min_meas, bus.max_meas, bus.sum_meas, bus.meas_count);
        end
        tick();
        checks++;
        if (bus.meas_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_width: meas_valid=%b required 0", bus.meas_valid);
        end
        $display("single: last=%0d cnt=%0d", bus.last_meas, bus.meas_count);
    endtask

    task automatic test_multi();
        do_clear();
        measure(20);
        measure(5);
        measure(300);
        checks++;
        if (bus.min_meas !== 32'd5 || bus.max_meas !== 32'd300 || bus.sum_meas !== 33'd325 ||
            bus.meas_count !== 4'd3 || bus.sum_ovf !== 1'b0 || bus.cnt_ovf !== 1'b0 ||
            bus.last_meas !== 32'd300) begin
            errors++;
            $display("FAIL multi: min=%0d max=%0d sum=%0d cnt=%0d last=%0d ovf=%b%b, required 5/300/325/3/300/00",
                     bus.min_meas, bus.max_meas, bus.sum_meas, bus.meas_count, bus.last_meas,
                     bus.sum_ovf, bus.cnt_ovf);
        end
        $display("multi: min=%0d max=%0d sum=%0d", bus.min_meas, bus.max_meas, bus.sum_meas);
    endtask

    task automatic test_start_stop_same();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        tick();
        checks++;
        if (bus.meas_valid !== 1'b1 || bus.last_meas !== 32'd0 || bus.min_meas !== 32'd0 ||
            bus.meas_count !== 4'd4 || bus.sum_meas !== 33'd325) begin
            errors++;
            $display("FAIL run_start_stop: valid=%b last=%0d min=%0d cnt=%0d sum=%0d, required 1/0/0/4/325",
                     bus.meas_valid, bus.last_meas, bus.min_meas, bus.meas_count, bus.sum_meas);
        end
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.meas_valid !== 1'b0 || bus.meas_count !== 4'd4) begin
            errors++;
            $display("FAIL idle_start_stop: valid=%b cnt=%0d, required 0/4", bus.meas_valid, bus.meas_count);
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        tick();
        checks++;
        if (bus.meas_valid !== 1'b1 || bus.last_meas !== 32'd4 || bus.meas_count !== 4'd5 ||
            bus.max_meas !== 32'd300) begin
            errors++;
            $display("FAIL idle_start_runs: valid=%b last=%0d cnt=%0d max=%0d, required 1/4/5/300",
                     bus.meas_valid, bus.last_meas, bus.meas_count, bus.max_meas);
        end
        $display("start_stop_same: last=%0d cnt=%0d", bus.last_meas, bus.meas_count);
    endtask

    task automatic test_rst_mid();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.meas_valid !== 1'b0 || bus.meas_count !== 4'd0 || bus.last_meas !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid: valid=%b cnt=%0d last=%0d, required 0/0/0",
                     bus.meas_valid, bus.meas_count, bus.last_meas);
        end
        $display("rst_mid: cnt=%0d", bus.meas_count);
    endtask

    task automatic test_saturation();
        do_clear();
        capture_forced(32'hFFFFFFFF);
        capture_forced(32'hFFFFFFFF);
        checks++;
        if (bus.sum_meas !== 33'h1FFFFFFFE || bus.sum_ovf !== 1'b0) begin
            errors++;
            $display("FAIL sum_pre_sat: sum=%0h ovf=%b, required 1fffffffe/0", bus.sum_meas, bus.sum_ovf);
        end
        capture_forced(32'hFFFFFFFF);
        checks++;
        if (bus.sum_meas !== 33'h1FFFFFFFF || bus.sum_ovf !== 1'b1 || bus.meas_count !== 4'd3 ||
            bus.max_meas !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL sum_sat: sum=%0h ovf=%b cnt=%0d max=%0h, required 1ffffffff/1/3/ffffffff",
                     bus.sum_meas, bus.sum_ovf, bus.meas_count, bus.max_meas);
        end
        do_clear();
        repeat (15) capture_forced(32'd5);
        checks++;
        if (bus.meas_count !== 4'd15 || bus.cnt_ovf !== 1'b0) begin
            errors++;
            $display("FAIL cnt_full: cnt=%0d ovf=%b, required 15/0", bus.meas_count, bus.cnt_ovf);
        end
        capture_forced(32'd5);
        checks++;
        if (bus.meas_count !== 4'd15 || bus.cnt_ovf !== 1'b1 || bus.sum_meas !== 33'd80 ||
            bus.sum_ovf !== 1'b0) begin
            errors++;
            $display("FAIL cnt_sat: cnt=%0d ovf=%b sum=%0d sum_ovf=%b, required 15/1/80/0",
                     bus.meas_count, bus.cnt_ovf, bus.sum_meas, bus.sum_ovf);
        end
        force_en = 1'b0;
        $display("saturation: cnt=%0d cnt_ovf=%b", bus.meas_count, bus.cnt_ovf);
    endtask

    task automatic test_clear_capture();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop  = 1'b0;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        checks++;
        if (bus.meas_valid !== 1'b1 || bus.last_meas !== 32'd0 || bus.min_meas !== 32'hFFFFFFFF ||
            bus.max_meas !== 32'd0 || bus.sum_meas !== '0 || bus.meas_count !== '0 ||
            bus.sum_ovf !== 1'b0 || bus.cnt_ovf !== 1'b0) begin
            errors++;
            $display("FAIL clear_capture: valid=%b last=%0h min=%0h max=%0h sum=%0h cnt=%0d ovf=%b%b, required 1/0/ffffffff/0/0/0/00",
                     bus.meas_valid, bus.last_meas, bus.min_meas, bus.max_meas, bus.sum_meas,
                     bus.meas_count, bus.sum_ovf, bus.cnt_ovf);
        end
        measure(7);
        checks++;
        if (bus.min_meas !== 32'd7 || bus.max_meas !== 32'd7 || bus.last_meas !== 32'd7 ||
            bus.sum_meas !== 33'd7 || bus.meas_count !== 4'd1) begin
            errors++;
            $display("FAIL after_clear: min=%0d max=%0d last=%0d sum=%0d cnt=%0d, required 7/7/7/7/1",
                     bus.min_meas, bus.max_meas, bus.last_meas, bus.sum_meas, bus.meas_count);
        end
        $display("clear_capture: min=%0d cnt=%0d", bus.min_meas, bus.meas_count);
    endtask

    task automatic test_hist();
        logic [15:0] exp_bins [8];
        do_clear();
        measure(3);
        measure(17);
        measure(200);
        for (int i = 0; i < 8; i++) exp_bins[i] = 16'd0;
`ifdef TIMER_STATS_HIST_EN
        exp_bins[0] = 16'd1;
        exp_bins[1] = 16'd1;
        exp_bins[7] = 16'd1;
`endif
        for (int i = 0; i < 8; i++) begin
            bus.hist_sel = 3'(i);
            tick();
            checks++;
            if (bus.hist_cnt !== exp_bins[i]) begin
                errors++;
                $display("FAIL hist_bin%0d: hist_cnt=%0d required %0d", i, bus.hist_cnt, exp_bins[i]);
            end
            $display("hist: bin%0d=%0d", i, bus.hist_cnt);
        end
    endtask

    initial begin
        rst          = 1'b1;
        force_en     = 1'b0;
        force_val    = '0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.clear    = 1'b0;
        bus.hist_sel = 3'd0;
        test_reset();
        test_single();
        test_multi();
        test_start_stop_same();
        test_rst_mid();
        test_saturation();
        test_clear_capture();
        test_hist();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
